// File: rtl/csi_tx_pixel_packer_pkg.sv
// Shared RAW10 packing constants and helpers for the CSI-2 transmit pixel path.
package csi_tx_pixel_packer_pkg;

    localparam int RAW10_GROUP_PIXELS = 4;
    localparam int RAW10_GROUP_BYTES  = 5;
    localparam int ACC_W              = RAW10_GROUP_BYTES * 8;

    // Fifth byte of a RAW10 group: two LSBs of each pixel, P0 in the lowest bits.
    function automatic logic [7:0] raw10_lsb_byte(input logic [5:0] lsb_p210,
                                                   input logic [1:0] lsb_p3);
        return {lsb_p3, lsb_p210};
    endfunction

endpackage

// File: rtl/altera_generic_fifo.sv
// Single-clock word FIFO with optional show-ahead head output; q reads as zero while empty.
module altera_generic_fifo #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 512,
    parameter int DC_FIFO   = 0,
    parameter int SHOWAHEAD = 1
) (
    input  logic             clock,
    input  logic             aclr,
    input  logic [WIDTH-1:0] data,
    input  logic             wrreq,
    input  logic             rdreq,
    output logic [WIDTH-1:0] q,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             fresh_q;
    logic             do_wr;
    logic             do_rd;

    // In dual-clock mode the first word into an empty FIFO is hidden one extra cycle.
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0) || ((DC_FIFO != 0) && fresh_q);
    assign do_wr = wrreq && !full;
    assign do_rd = rdreq && !empty;

    always_ff @(posedge clock) begin
        if (do_wr) begin
            mem[wr_ptr] <= data;
        end
    end

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            fresh_q <= 1'b0;
        end else begin
            fresh_q <= do_wr && (count == '0);
            if (do_wr) begin
                wr_ptr <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    generate
        if (SHOWAHEAD != 0) begin : g_showahead
            assign q = empty ? '0 : mem[rd_ptr];
        end else begin : g_normal
            logic [WIDTH-1:0] q_r;
            always_ff @(posedge clock or posedge aclr) begin
                if (aclr) begin
                    q_r <= '0;
                end else if (do_rd) begin
                    q_r <= mem[rd_ptr];
                end
            end
            assign q = q_r;
        end
    endgenerate

endmodule

// File: rtl/csi_tx_pixel_packer.sv
// RAW10 pixel packer: packs 10-bit pixels into little-endian 32-bit words and
// buffers them, flagging when a complete line is available for the assembler.
module csi_tx_pixel_packer
    import csi_tx_pixel_packer_pkg::*;
#(
    parameter int LINE_WIDTH = 640,
    parameter int DEPTH      = 512
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  pix_data,
    input  logic        pix_valid,
    input  logic        pix_eol,
    output logic        pix_ready,
    output logic [31:0] fifo_data,
    output logic        fifo_not_empty,
    output logic        fifo_line_ready,
    input  logic        fifo_read_ack,
    output logic        err_line_length
);

    localparam int WORDS_PER_LINE = LINE_WIDTH * 10 / 32;
    localparam int PIX_W          = $clog2(LINE_WIDTH);
    localparam int WRD_W          = $clog2(WORDS_PER_LINE);
    localparam int LB_W           = $clog2(DEPTH / WORDS_PER_LINE + 2);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] acc_app;
    logic [2:0]       cnt_q;
    logic [2:0]       cnt_d;
    logic [2:0]       cnt_app;
    logic [5:0]       lsb_q;
    logic [PIX_W-1:0] pix_cnt;
    logic [WRD_W-1:0] wr_word_cnt;
    logic [WRD_W-1:0] rd_word_cnt;
    logic [LB_W-1:0]  lines_buffered;
    logic [31:0]      word_d;
    logic             fifo_full;
    logic             fifo_empty;
    logic             accept;
    logic             word_wr;
    logic             word_rd;
    logic             last_pix;
    logic             group_end;
    logic             line_done;
    logic             line_taken;

    assign pix_ready       = !fifo_full;
    assign accept          = pix_valid && pix_ready;
    assign last_pix        = (pix_cnt == PIX_W'(LINE_WIDTH-1));
    assign group_end       = (pix_cnt[1:0] == 2'(RAW10_GROUP_PIXELS-1));
    assign word_rd         = fifo_read_ack && !fifo_empty;
    assign line_done       = word_wr && (wr_word_cnt == WRD_W'(WORDS_PER_LINE-1));
    assign line_taken      = word_rd && (rd_word_cnt == WRD_W'(WORDS_PER_LINE-1));
    assign fifo_not_empty  = !fifo_empty;
    assign fifo_line_ready = (lines_buffered != '0);

    // Bytes above cnt_q are always zero, so appending is a plain OR at the fill point.
    always_comb begin
        acc_app = acc_q | (ACC_W'(pix_data[9:2]) << {cnt_q, 3'b000});
        cnt_app = cnt_q + 3'd1;
        if (group_end) begin
            acc_app = acc_app | (ACC_W'(raw10_lsb_byte(lsb_q, pix_data[1:0])) << {cnt_app, 3'b000});
            cnt_app = cnt_q + 3'd2;
        end
        word_wr = accept && (cnt_app >= 3'd4);
        word_d  = acc_app[31:0];
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        if (accept) begin
            if (word_wr) begin
                acc_d = acc_app >> 32;
                cnt_d = cnt_app - 3'd4;
            end else begin
                acc_d = acc_app;
                cnt_d = cnt_app;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q           <= '0;
            cnt_q           <= '0;
            lsb_q           <= '0;
            pix_cnt         <= '0;
            wr_word_cnt     <= '0;
            rd_word_cnt     <= '0;
            lines_buffered  <= '0;
            err_line_length <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            if (accept) begin
                lsb_q   <= {pix_data[1:0], lsb_q[5:2]};
                pix_cnt <= last_pix ? '0 : pix_cnt + PIX_W'(1);
                // Length is only reported; packing keeps following the counter.
                if (pix_eol != last_pix) begin
                    err_line_length <= 1'b1;
                end
            end
            if (word_wr) begin
                wr_word_cnt <= (wr_word_cnt == WRD_W'(WORDS_PER_LINE-1)) ? '0 : wr_word_cnt + WRD_W'(1);
            end
            if (word_rd) begin
                rd_word_cnt <= (rd_word_cnt == WRD_W'(WORDS_PER_LINE-1)) ? '0 : rd_word_cnt + WRD_W'(1);
            end
            case ({line_done, line_taken})
                2'b10:   lines_buffered <= lines_buffered + LB_W'(1);
                2'b01:   lines_buffered <= lines_buffered - LB_W'(1);
                default: ;
            endcase
        end
    end

    altera_generic_fifo #(
        .WIDTH     (32),
        .DEPTH     (DEPTH),
        .DC_FIFO   (0),
        .SHOWAHEAD (1)
    ) u_fifo (
        .clock (clk),
        .aclr  (!rst_n),
        .data  (word_d),
        .wrreq (word_wr),
        .rdreq (fifo_read_ack),
        .q     (fifo_data),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

endmodule

// File: tb/tb_csi_tx_pixel_packer.sv
// Randomized bench for the RAW10 packer, checked every cycle against a byte-stream model.
module tb_csi_tx_pixel_packer;

    localparam int LW    = 640;
    localparam int DEPTH = 512;
    localparam int WPL   = LW * 10 / 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  pix_data = '0;
    logic        pix_valid = 1'b0;
    logic        pix_eol = 1'b0;
    logic        pix_ready;
    logic [31:0] fifo_data;
    logic        fifo_not_empty;
    logic        fifo_line_ready;
    logic        fifo_read_ack = 1'b0;
    logic        err_line_length;

    csi_tx_pixel_packer #(.LINE_WIDTH(LW), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pix_data        (pix_data),
        .pix_valid       (pix_valid),
        .pix_eol         (pix_eol),
        .pix_ready       (pix_ready),
        .fifo_data       (fifo_data),
        .fifo_not_empty  (fifo_not_empty),
        .fifo_line_ready (fifo_line_ready),
        .fifo_read_ack   (fifo_read_ack),
        .err_line_length (err_line_length)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model state: byte stream -> word queue, plus totals since the last reset.
    logic [31:0] m_q[$];
    logic [7:0]  m_b[$];
    logic [9:0]  m_grp[4];
    int          m_pix;
    int          m_wr;
    int          m_rd;
    bit          m_err;
    int          prev_size;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic int m_lines();
        return m_wr / WPL - m_rd / WPL;
    endfunction

    task automatic model_clear();
        m_q.delete();
        m_b.delete();
        m_pix = 0;
        m_wr = 0;
        m_rd = 0;
        m_err = 0;
        prev_size = 0;
    endtask

    task automatic model_step();
        logic [31:0] w;
        if (fifo_read_ack && fifo_not_empty) begin
            if (m_q.size() > 0) void'(m_q.pop_front());
            m_rd++;
        end
        if (pix_valid && pix_ready) begin
            if (pix_eol != (m_pix == LW-1)) m_err = 1;
            m_grp[m_pix % 4] = pix_data;
            m_b.push_back(pix_data[9:2]);
            if (m_pix % 4 == 3)
                m_b.push_back({m_grp[3][1:0], m_grp[2][1:0], m_grp[1][1:0], m_grp[0][1:0]});
            if (m_b.size() >= 4) begin
                w = {m_b[3], m_b[2], m_b[1], m_b[0]};
                repeat (4) void'(m_b.pop_front());
                m_q.push_back(w);
                m_wr++;
            end
            m_pix = (m_pix + 1) % LW;
        end
    endtask

    task automatic compare();
        chk("pix_ready", {31'b0, pix_ready}, {31'b0, m_q.size() < DEPTH});
        chk("line_ready", {31'b0, fifo_line_ready}, {31'b0, m_lines() != 0});
        chk("err_line_length", {31'b0, err_line_length}, {31'b0, m_err});
        if (fifo_not_empty) begin
            if (m_q.size() == 0) chk("not_empty_spurious", {31'b0, fifo_not_empty}, 32'd0);
            else                 chk("fifo_data", fifo_data, m_q[0]);
        end else if (m_q.size() > 0 && prev_size > 0) begin
            chk("not_empty_late", {31'b0, fifo_not_empty}, 32'd1);
        end
    endtask

    // One clock: check at the falling edge, drive, predict the next rising edge.
    // eol_mode 0: correct eol; 1: eol only on pixel 100.
    task automatic cyc(input bit v, input logic [9:0] d, input int eol_mode, input bit ack);
        compare();
        pix_valid     = v;
        pix_data      = d;
        pix_eol       = (eol_mode == 0) ? (m_pix == LW-1) : (m_pix == 100);
        fifo_read_ack = ack;
        prev_size     = m_q.size();
        model_step();
        @(negedge clk);
    endtask

    function automatic logic [9:0] rnd_pix();
        return 10'($urandom_range(0, 1023));
    endfunction

    task automatic reset_checks(input string tag);
        chk({tag, "_pix_ready"}, {31'b0, pix_ready}, 32'd1);
        chk({tag, "_not_empty"}, {31'b0, fifo_not_empty}, 32'd0);
        chk({tag, "_line_ready"}, {31'b0, fifo_line_ready}, 32'd0);
        chk({tag, "_fifo_data"}, fifo_data, 32'd0);
        chk({tag, "_err"}, {31'b0, err_line_length}, 32'd0);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        pix_valid = 1'b0;
        pix_eol = 1'b0;
        fifo_read_ack = 1'b0;
        model_clear();
        #1;
        reset_checks("rst_async");
        @(negedge clk);
        reset_checks("rst_held");
        rst_n = 1'b1;
    endtask

    task automatic drain();
        int n = 0;
        while ((m_q.size() != 0 || fifo_not_empty) && n < 2000) begin
            cyc(1'b0, '0, 0, fifo_not_empty);
            n++;
        end
        chk("drain_model_empty", m_q.size(), 32'd0);
        chk("drain_not_empty", {31'b0, fifo_not_empty}, 32'd0);
    endtask

    initial begin
        logic [9:0] first8[8];
        int n;
        int wr0;
        first8 = '{10'h3FF, 10'h000, 10'h2AA, 10'h155, 10'h004, 10'h008, 10'h00C, 10'h010};
        model_clear();

        repeat (2) @(negedge clk);
        reset_checks("por");
        rst_n = 1'b1;

        // Line 1: known first group, no reads.
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, first8[i], 0, 1'b0);
            if (i == 3) begin
                chk("first_word_dut", fifo_data, 32'h55AA00FF);
                chk("first_word_model", m_q[0], 32'h55AA00FF);
            end
        end
        chk("second_word_model", m_q[1], 32'h03020163);
        for (int i = 8; i < LW; i++) begin
            if (i == LW-1) chk("line1_not_ready_yet", {31'b0, fifo_line_ready}, 32'd0);
            cyc(1'b1, rnd_pix(), 0, 1'b0);
        end
        chk("line1_ready", {31'b0, fifo_line_ready}, 32'd1);
        chk("line1_words", m_q.size(), 32'd200);

        // Line 2 while popping line 1 so its last pop meets line 2's last write.
        for (int i = 0; i < LW; i++)
            cyc(1'b1, rnd_pix(), 0, i >= LW - WPL);
        chk("coincide_line_ready", {31'b0, fifo_line_ready}, 32'd1);
        chk("coincide_lines", m_lines(), 32'd1);
        chk("coincide_words", m_q.size(), 32'd200);
        drain();

        // Three lines without reads: stall at full depth, then resume.
        wr0 = m_wr;
        n = 0;
        while (pix_ready && n < 2000) begin
            cyc(1'b1, rnd_pix(), 0, 1'b0);
            n++;
        end
        chk("stall_depth", m_q.size(), 32'd512);
        chk("stall_ready_low", {31'b0, pix_ready}, 32'd0);
        n = 0;
        while (m_wr < wr0 + 3*WPL && n < 5000) begin
            cyc(1'b1, rnd_pix(), 0, ($urandom_range(0, 1) == 1) && fifo_not_empty);
            n++;
        end
        chk("stall_three_lines", m_wr - wr0, 32'd600);
        drain();

        // Misplaced eol on pixel 100, then a clean line: flag stays set.
        for (int i = 0; i < LW; i++)
            cyc(1'b1, rnd_pix(), 1, fifo_not_empty);
        chk("err_set", {31'b0, err_line_length}, 32'd1);
        for (int i = 0; i < LW; i++)
            cyc(1'b1, rnd_pix(), 0, fifo_not_empty);
        chk("err_sticky", {31'b0, err_line_length}, 32'd1);
        drain();

        // Reset in the middle of a line, then a clean line from pixel 0.
        for (int i = 0; i < 300; i++)
            cyc(1'b1, rnd_pix(), 0, 1'b0);
        pulse_reset();
        for (int i = 0; i < LW; i++)
            cyc(1'b1, rnd_pix(), 0, ($urandom_range(0, 3) == 0) && fifo_not_empty);
        drain();
        chk("post_reset_written", m_wr, 32'd200);
        chk("post_reset_read", m_rd, 32'd200);

        // Random valid gaps and reads, including acks while empty.
        wr0 = m_wr;
        n = 0;
        while (m_wr < wr0 + 2*WPL && n < 6000) begin
            cyc($urandom_range(0, 3) != 0, rnd_pix(), 0, $urandom_range(0, 1) == 1);
            n++;
        end
        chk("random_two_lines", m_wr - wr0, 32'd400);
        drain();
        cyc(1'b0, '0, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
